// File: rtl/mem_bus_arbiter_pkg.sv
// Shared types for the fetch/data bus arbiter: channel ids, FSM states and
// request mode encodings.
package mem_bus_arbiter_pkg;

  typedef enum logic {
    CH_FETCH = 1'b0,
    CH_MEM   = 1'b1
  } ch_id_e;

  typedef enum logic {
    IDLE = 1'b0,
    WAIT = 1'b1
  } state_e;

  localparam logic MODE_READ  = 1'b0;
  localparam logic MODE_WRITE = 1'b1;

  // The channel that did not win last time takes a tie.
  function automatic ch_id_e other_ch(input ch_id_e ch);
    return (ch == CH_FETCH) ? CH_MEM : CH_FETCH;
  endfunction

endpackage

// File: rtl/mem_bus_arbiter_slot.sv
// Single-entry request buffer for one channel: holds a request from capture
// until its response is returned, and flags requests that arrive meanwhile.
module req_slot
  import mem_bus_arbiter_pkg::*;
#(
  parameter  int unsigned ADDR_W = 32,
  parameter  int unsigned DATA_W = 32,
  localparam int unsigned STRB_W = DATA_W / 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_en,
  input  logic              req_mode,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [DATA_W-1:0] req_wdata,
  input  logic [STRB_W-1:0] req_wstrb,
  input  logic              clr,
  output logic              valid,
  output logic              mode,
  output logic [ADDR_W-1:0] addr,
  output logic [DATA_W-1:0] wdata,
  output logic [STRB_W-1:0] wstrb,
  output logic              viol_c
);

  logic accept_c;

  // A request coinciding with the clear of the previous one is accepted.
  assign accept_c = req_en && (!valid || clr);
  assign viol_c   = req_en && valid && !clr;

  always_ff @(posedge clk) begin
    if (rst) begin
      valid <= 1'b0;
      mode  <= MODE_READ;
      addr  <= '0;
      wdata <= '0;
      wstrb <= '0;
    end else if (accept_c) begin
      valid <= 1'b1;
      mode  <= req_mode;
      addr  <= req_addr;
      wdata <= req_wdata;
      wstrb <= req_wstrb;
    end else if (clr) begin
      valid <= 1'b0;
    end
  end

endmodule

// File: rtl/mem_bus_arbiter.sv
// Merges the fetch and data request channels onto one downstream port with
// round-robin arbitration, one outstanding transaction, and response routing.
module mem_bus_arbiter
  import mem_bus_arbiter_pkg::*;
#(
  parameter  int unsigned ADDR_W = 32,
  parameter  int unsigned DATA_W = 32,
  localparam int unsigned STRB_W = DATA_W / 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              f_req_en,
  input  logic              f_req_mode,
  input  logic [ADDR_W-1:0] f_req_addr,
  input  logic [DATA_W-1:0] f_req_wdata,
  input  logic [STRB_W-1:0] f_req_wstrb,
  output logic              f_resp_en,
  output logic [DATA_W-1:0] f_resp_data,
  input  logic              m_req_en,
  input  logic              m_req_mode,
  input  logic [ADDR_W-1:0] m_req_addr,
  input  logic [DATA_W-1:0] m_req_wdata,
  input  logic [STRB_W-1:0] m_req_wstrb,
  output logic              m_resp_en,
  output logic [DATA_W-1:0] m_resp_data,
  output logic              bus_req_en,
  output logic              bus_req_mode,
  output logic [ADDR_W-1:0] bus_req_addr,
  output logic [DATA_W-1:0] bus_req_wdata,
  output logic [STRB_W-1:0] bus_req_wstrb,
  input  logic              bus_resp_en,
  input  logic [DATA_W-1:0] bus_resp_data,
  output logic              proto_err
);

  state_e state, state_d;
  ch_id_e owner, owner_d, last_grant, last_grant_d, grant_ch_c;
  logic   grant_c, f_clr_c, m_clr_c;

  logic              f_valid, f_mode, f_viol_c;
  logic [ADDR_W-1:0] f_addr;
  logic [DATA_W-1:0] f_wdata;
  logic [STRB_W-1:0] f_wstrb;
  logic              m_valid, m_mode, m_viol_c;
  logic [ADDR_W-1:0] m_addr;
  logic [DATA_W-1:0] m_wdata;
  logic [STRB_W-1:0] m_wstrb;

  logic              sel_mode_c;
  logic [ADDR_W-1:0] sel_addr_c;
  logic [DATA_W-1:0] sel_wdata_c;
  logic [STRB_W-1:0] sel_wstrb_c;

  req_slot #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) u_f_slot (
    .clk(clk), .rst(rst),
    .req_en(f_req_en), .req_mode(f_req_mode), .req_addr(f_req_addr),
    .req_wdata(f_req_wdata), .req_wstrb(f_req_wstrb), .clr(f_clr_c),
    .valid(f_valid), .mode(f_mode), .addr(f_addr), .wdata(f_wdata),
    .wstrb(f_wstrb), .viol_c(f_viol_c)
  );

  req_slot #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) u_m_slot (
    .clk(clk), .rst(rst),
    .req_en(m_req_en), .req_mode(m_req_mode), .req_addr(m_req_addr),
    .req_wdata(m_req_wdata), .req_wstrb(m_req_wstrb), .clr(m_clr_c),
    .valid(m_valid), .mode(m_mode), .addr(m_addr), .wdata(m_wdata),
    .wstrb(m_wstrb), .viol_c(m_viol_c)
  );

  // Arbitration and response routing; grants only from registered slot state.
  always_comb begin
    state_d      = state;
    owner_d      = owner;
    last_grant_d = last_grant;
    grant_c      = 1'b0;
    grant_ch_c   = CH_FETCH;
    f_clr_c      = 1'b0;
    m_clr_c      = 1'b0;
    case (state)
      IDLE: begin
        if (f_valid && m_valid) begin
          grant_c    = 1'b1;
          grant_ch_c = other_ch(last_grant);
        end else if (f_valid) begin
          grant_c    = 1'b1;
          grant_ch_c = CH_FETCH;
        end else if (m_valid) begin
          grant_c    = 1'b1;
          grant_ch_c = CH_MEM;
        end
        if (grant_c) begin
          owner_d      = grant_ch_c;
          last_grant_d = grant_ch_c;
          state_d      = WAIT;
        end
      end
      WAIT: begin
        if (bus_resp_en) begin
          state_d = IDLE;
          if (owner == CH_FETCH) f_clr_c = 1'b1;
          else                   m_clr_c = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
    sel_mode_c  = (grant_ch_c == CH_MEM) ? m_mode  : f_mode;
    sel_addr_c  = (grant_ch_c == CH_MEM) ? m_addr  : f_addr;
    sel_wdata_c = (grant_ch_c == CH_MEM) ? m_wdata : f_wdata;
    sel_wstrb_c = (grant_ch_c == CH_MEM) ? m_wstrb : f_wstrb;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state         <= IDLE;
      owner         <= CH_FETCH;
      last_grant    <= CH_FETCH;
      bus_req_en    <= 1'b0;
      bus_req_mode  <= MODE_READ;
      bus_req_addr  <= '0;
      bus_req_wdata <= '0;
      bus_req_wstrb <= '0;
      f_resp_en     <= 1'b0;
      f_resp_data   <= '0;
      m_resp_en     <= 1'b0;
      m_resp_data   <= '0;
      proto_err     <= 1'b0;
    end else begin
      state      <= state_d;
      owner      <= owner_d;
      last_grant <= last_grant_d;
      bus_req_en <= grant_c;
      if (grant_c) begin
        bus_req_mode  <= sel_mode_c;
        bus_req_addr  <= sel_addr_c;
        bus_req_wdata <= sel_wdata_c;
        bus_req_wstrb <= sel_wstrb_c;
      end
      f_resp_en <= f_clr_c;
      m_resp_en <= m_clr_c;
      if (f_clr_c) f_resp_data <= bus_resp_data;
      if (m_clr_c) m_resp_data <= bus_resp_data;
      proto_err <= proto_err | f_viol_c | m_viol_c;
    end
  end

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Randomized scoreboard bench for mem_bus_arbiter: a channel/memory driver
// issues traffic, a monitor checks every bus request and routed response.
module tb_mem_bus_arbiter;

  localparam int unsigned ADDR_W = 32;
  localparam int unsigned DATA_W = 32;
  localparam int unsigned STRB_W = DATA_W / 8;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic              rst;
  logic              f_req_en, f_req_mode, f_resp_en;
  logic [ADDR_W-1:0] f_req_addr;
  logic [DATA_W-1:0] f_req_wdata, f_resp_data;
  logic [STRB_W-1:0] f_req_wstrb;
  logic              m_req_en, m_req_mode, m_resp_en;
  logic [ADDR_W-1:0] m_req_addr;
  logic [DATA_W-1:0] m_req_wdata, m_resp_data;
  logic [STRB_W-1:0] m_req_wstrb;
  logic              bus_req_en, bus_req_mode, bus_resp_en, proto_err;
  logic [ADDR_W-1:0] bus_req_addr;
  logic [DATA_W-1:0] bus_req_wdata, bus_resp_data;
  logic [STRB_W-1:0] bus_req_wstrb;

  mem_bus_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
    .clk(clk), .rst(rst),
    .f_req_en(f_req_en), .f_req_mode(f_req_mode), .f_req_addr(f_req_addr),
    .f_req_wdata(f_req_wdata), .f_req_wstrb(f_req_wstrb),
    .f_resp_en(f_resp_en), .f_resp_data(f_resp_data),
    .m_req_en(m_req_en), .m_req_mode(m_req_mode), .m_req_addr(m_req_addr),
    .m_req_wdata(m_req_wdata), .m_req_wstrb(m_req_wstrb),
    .m_resp_en(m_resp_en), .m_resp_data(m_resp_data),
    .bus_req_en(bus_req_en), .bus_req_mode(bus_req_mode),
    .bus_req_addr(bus_req_addr), .bus_req_wdata(bus_req_wdata),
    .bus_req_wstrb(bus_req_wstrb),
    .bus_resp_en(bus_resp_en), .bus_resp_data(bus_resp_data),
    .proto_err(proto_err)
  );

  typedef struct packed {
    logic              mode;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] wdata;
    logic [STRB_W-1:0] wstrb;
  } req_t;

  typedef struct packed {
    logic              ch;
    logic [DATA_W-1:0] data;
  } rsp_t;

  // Driver-owned model state (channel 0 = fetch, 1 = data).
  int   issued[2];
  int   issue_cyc[2];
  req_t req_model[2];
  bit   exp_err;
  bit   mem_active;
  int   mem_seen;
  int   mem_lat;
  bit   hold_mem;
  bit   to_flag;

  // Monitor-owned model state.
  int   cyc;
  int   done_cnt[2];
  int   gnt_cnt[2];
  int   gnt_tot, rsp_tot;
  int   last_g;
  int   cur_owner;
  bit   to_seen;
  rsp_t exp_q[$];
  int   n_tests, n_fail;

  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  task automatic bad(input string nm);
    n_tests++;
    n_fail++;
    $display("FAIL %s: event not allowed by the model (cycle %0d)", nm, cyc);
  endtask

  // Monitor: checks DUT outputs just after each active edge.
  always @(posedge clk) begin
    rsp_t e;
    bit   el0, el1;
    int   g;
    #1;
    cyc++;
    if (rst) begin
      chk("reset_outputs", 128'(|{bus_req_en, bus_req_mode, bus_req_addr, bus_req_wdata,
          bus_req_wstrb, f_resp_en, f_resp_data, m_resp_en, m_resp_data, proto_err}), 128'd0);
      done_cnt  = '{0, 0};
      gnt_cnt   = '{0, 0};
      gnt_tot   = 0;
      rsp_tot   = 0;
      last_g    = 0;
      cur_owner = 0;
      exp_q.delete();
    end else begin
      if (bus_resp_en && gnt_tot != rsp_tot) begin
        exp_q.push_back({1'(cur_owner), bus_resp_data});
        rsp_tot++;
      end
      if (f_resp_en || m_resp_en) begin
        if (exp_q.size() == 0) bad("stray_resp");
        else begin
          e = exp_q.pop_front();
          chk("resp_route", 128'({f_resp_en, m_resp_en}), e.ch ? 128'd1 : 128'd2);
          chk("resp_data", 128'(e.ch ? m_resp_data : f_resp_data), 128'(e.data));
          done_cnt[e.ch]++;
        end
      end else if (exp_q.size() != 0) begin
        bad("resp_missing");
        e = exp_q.pop_front();
        done_cnt[e.ch]++;
      end
      if (bus_req_en) begin
        el0 = (issued[0] - gnt_cnt[0] == 1) && (issue_cyc[0] <= cyc - 2);
        el1 = (issued[1] - gnt_cnt[1] == 1) && (issue_cyc[1] <= cyc - 2);
        chk("bus_one_outstanding", 128'(gnt_tot - rsp_tot), 128'd0);
        if (!el0 && !el1) bad("bus_req_unexpected");
        else begin
          g = (el0 && el1) ? 1 - last_g : (el1 ? 1 : 0);
          chk("bus_fields", 128'({bus_req_mode, bus_req_addr, bus_req_wdata, bus_req_wstrb}),
              128'(req_model[g]));
          gnt_cnt[g]++;
          gnt_tot++;
          last_g    = g;
          cur_owner = g;
        end
      end
      chk("proto_err", 128'(proto_err), 128'(exp_err));
    end
    if (to_flag && !to_seen) begin
      to_seen = 1'b1;
      bad("bounded_wait_timeout");
    end
  end

  task automatic clear_inputs();
    f_req_en = 1'b0; m_req_en = 1'b0; bus_resp_en = 1'b0;
  endtask

  task automatic reset_drv_model();
    clear_inputs();
    issued     = '{0, 0};
    issue_cyc  = '{0, 0};
    exp_err    = 1'b0;
    mem_active = 1'b0;
    mem_seen   = 0;
    mem_lat    = 0;
  endtask

  task automatic drive(input int ch, input req_t r);
    if (ch == 0) begin
      f_req_en = 1'b1; f_req_mode = r.mode; f_req_addr = r.addr;
      f_req_wdata = r.wdata; f_req_wstrb = r.wstrb;
    end else begin
      m_req_en = 1'b1; m_req_mode = r.mode; m_req_addr = r.addr;
      m_req_wdata = r.wdata; m_req_wstrb = r.wstrb;
    end
  endtask

  task automatic new_req(input int ch, input req_t r);
    drive(ch, r);
    issued[ch]++;
    issue_cyc[ch] = cyc;
    req_model[ch] = r;
  endtask

  // A pulse while the channel is still outstanding must be dropped.
  task automatic viol_req(input int ch, input req_t r);
    drive(ch, r);
    exp_err = 1'b1;
  endtask

  function automatic req_t rand_req();
    req_t r;
    r.mode  = 1'($urandom_range(0, 1));
    r.addr  = $urandom;
    r.wdata = $urandom;
    r.wstrb = STRB_W'($urandom_range(0, 15));
    return r;
  endfunction

  // One driver step at the falling edge: memory model plus optional random traffic.
  task automatic tick(input bit rnd, input bit viol_en);
    int resp_ch;
    bit free;
    clear_inputs();
    resp_ch = -1;
    if (!hold_mem) begin
      if (!mem_active && gnt_tot > mem_seen) begin
        mem_active = 1'b1;
        mem_seen   = gnt_tot;
        mem_lat    = $urandom_range(0, 3);
      end
      if (mem_active) begin
        if (mem_lat == 0) begin
          bus_resp_en   = 1'b1;
          bus_resp_data = $urandom;
          mem_active    = 1'b0;
          resp_ch       = cur_owner;
        end else mem_lat--;
      end else if (rnd && $urandom_range(0, 40) == 0) begin
        bus_resp_en   = 1'b1;
        bus_resp_data = $urandom;
      end
    end
    if (rnd) begin
      for (int ch = 0; ch < 2; ch++) begin
        free = (issued[ch] == done_cnt[ch]);
        if ((free || (resp_ch == ch && $urandom_range(0, 2) == 0)) && $urandom_range(0, 3) == 0)
          new_req(ch, rand_req());
        else if (!free && resp_ch != ch && viol_en && $urandom_range(0, 63) == 0)
          viol_req(ch, rand_req());
      end
    end
  endtask

  task automatic drain();
    bit ok;
    ok = 1'b0;
    for (int k = 0; k < 300 && !ok; k++) begin
      @(negedge clk);
      tick(1'b0, 1'b0);
      ok = (issued[0] == done_cnt[0]) && (issued[1] == done_cnt[1]) &&
           !mem_active && (gnt_tot == mem_seen);
    end
    if (!ok) to_flag = 1'b1;
  endtask

  initial begin
    req_t r;
    bit   seen;
    hold_mem = 1'b0;
    to_flag  = 1'b0;
    f_req_mode = 1'b0; f_req_addr = '0; f_req_wdata = '0; f_req_wstrb = '0;
    m_req_mode = 1'b0; m_req_addr = '0; m_req_wdata = '0; m_req_wstrb = '0;
    bus_resp_data = '0;
    rst = 1'b1;
    reset_drv_model();
    repeat (3) @(negedge clk);
    rst = 1'b0;

    // Simultaneous requests right after reset: data channel must win.
    @(negedge clk);
    tick(1'b0, 1'b0);
    new_req(0, '{mode: 1'b0, addr: 32'h2000, wdata: 32'h0, wstrb: 4'h0});
    new_req(1, '{mode: 1'b1, addr: 32'h8000, wdata: 32'h55, wstrb: 4'hF});
    drain();

    for (int i = 0; i < 3000; i++) begin
      @(negedge clk);
      tick(1'b1, i >= 1500);
    end
    drain();

    // Reset while a transaction is outstanding; the late response is stray.
    @(negedge clk);
    tick(1'b0, 1'b0);
    hold_mem = 1'b1;
    new_req(0, '{mode: 1'b0, addr: 32'h1000, wdata: 32'h0, wstrb: 4'h0});
    seen = 1'b0;
    for (int k = 0; k < 20 && !seen; k++) begin
      @(negedge clk);
      tick(1'b0, 1'b0);
      seen = (gnt_tot != rsp_tot);
    end
    if (!seen) to_flag = 1'b1;
    @(negedge clk);
    rst = 1'b1;
    reset_drv_model();
    @(negedge clk);
    rst = 1'b0;
    hold_mem = 1'b0;
    bus_resp_en   = 1'b1;
    bus_resp_data = 32'hCAFE_F00D;
    @(negedge clk);
    bus_resp_en = 1'b0;
    repeat (3) @(negedge clk);

    // Fetch at 0x1000 followed by an illegal second fetch at 0x3000.
    @(negedge clk);
    tick(1'b0, 1'b0);
    new_req(0, '{mode: 1'b0, addr: 32'h1000, wdata: 32'h0, wstrb: 4'h0});
    @(negedge clk);
    tick(1'b0, 1'b0);
    r = '{mode: 1'b0, addr: 32'h3000, wdata: 32'h0, wstrb: 4'h0};
    viol_req(0, r);
    drain();
    @(negedge clk);
    tick(1'b0, 1'b0);
    new_req(1, '{mode: 1'b1, addr: 32'h8000, wdata: 32'h1234_5678, wstrb: 4'h3});
    drain();

    repeat (3) @(negedge clk);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
